fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of 128-bit fetch packets held (power of two, >= 2).
REQ-002 SHALL have port clock, input, 1, the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port enq_valid, input, 1, meaning an ICache response packet is offered.
REQ-005 SHALL have port enq_ready, output, 1, meaning a free packet slot exists.
REQ-006 SHALL have port enq_pc, input, 39, meaning the fetch virtual address of the packet.
REQ-007 SHALL have port enq_data, input, 128, meaning the ICache response data with the word at byte 0 in bits [31:0].
REQ-008 SHALL have port deq_valid, output, 1, meaning deq_inst and deq_pc are valid.
REQ-009 SHALL have port deq_ready, input, 1, meaning the decoder accepts the instruction.
REQ-010 SHALL have port deq_inst, output, 32, meaning the instruction word.
REQ-011 SHALL have port deq_pc, output, 39, meaning the address of deq_inst.
REQ-012 SHALL have port flush, input, 1, meaning redirect or kill: discard all contents.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, meaning the number of occupied packet slots.

Function
REQ-014 SHALL accept a packet on enq fire (enq_valid && enq_ready), storing enq_data, enq_pc[38:4] and start word index enq_pc[3:2]; enq_pc[1:0] is ignored.
REQ-015 SHALL drive enq_ready = (count < DEPTH) && !flush, independent of enq_valid and of same-cycle dequeue (no full-bypass).
REQ-016 SHALL present a stored packet no earlier than the cycle after its enq fire (no enq-to-deq bypass).
REQ-017 SHALL present words of the head packet in order from the start index through word 3, one per deq fire (deq_valid && deq_ready).
REQ-018 SHALL drive deq_pc = {head base[38:4], word index[1:0], 2'b00} and deq_inst = head data[32*idx +: 32].
REQ-019 SHALL pop the head packet on the deq fire of word 3, advancing the head pointer modulo DEPTH, with the next packet's start index used the following cycle.
REQ-020 SHALL drive deq_valid = (count != 0) && !flush, and SHALL drive deq_inst = 0 and deq_pc = 0 whenever deq_valid = 0.
REQ-021 SHALL update count by +1 on enq fire only, -1 on pop only, and leave it unchanged on simultaneous enq fire and pop.
REQ-022 SHALL, on flush, clear count, head/tail pointers and the word index on the next edge; enqueue and dequeue are suppressed that cycle.
REQ-023 SHALL wrap head and tail pointers from DEPTH-1 to 0 without loss or duplication.
REQ-024 SHALL hold deq_inst/deq_pc stable while deq_valid && !deq_ready.

Reset
REQ-025 SHALL on reset set count=0, head=tail=0, word index=0, giving enq_ready=1, deq_valid=0, deq_inst=0, deq_pc=0.
REQ-026 SHALL treat reset asserted mid-operation like flush, discarding all packets immediately (asynchronously).
REQ-027 SHALL not require reset of the packet data storage.

Structure
REQ-028 SHALL take FETCH_BYTES=16, INSTS_PER_FETCH=4, VADDR_BITS=39 and the fetch_packet_t typedef (data[127:0], base[38:4], start[1:0]) from shared package fetch_pkg.
REQ-029 SHALL be a single module with no sub-modules; storage is a flat register array of fetch_packet_t indexed by head/tail pointers.

Verification
REQ-030 Scenario: enq pc=0x1000, data=0x44444444_33333333_22222222_11111111, deq_ready=1 -> deq 0x11111111@0x1000, 0x22222222@0x1004, 0x33333333@0x1008, 0x44444444@0x100C on 4 consecutive cycles, then count=0.
REQ-031 Scenario: enq pc=0x2008 -> only two deqs, 0x2008 then 0x200C, then pop.
REQ-032 Scenario: deq_ready=0, enq 4 packets -> count=4, enq_ready=0; 5th enq_valid is held and not accepted until after the first pop.
REQ-033 Scenario: 10 packets streamed with random deq_ready -> pointers wrap, 40 words emerge in order with correct pc, and nothing is dropped.
REQ-034 Scenario: count=3 and word index=2, then flush pulse together with enq_valid -> next cycle count=0, deq_valid=0, and the enqueued packet is discarded.
REQ-035 Scenario: reset asserted mid-stream, between clock edges -> deq_valid=0 and enq_ready=1 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path constants and the packet record held by the fetch buffer.
package fetch_pkg;
    localparam int FETCH_BYTES     = 16;
    localparam int INSTS_PER_FETCH = 4;
    localparam int VADDR_BITS      = 39;

    typedef struct packed {
        logic [FETCH_BYTES*8-1:0] data;
        logic [VADDR_BITS-1:4]    base;
        logic [1:0]               start;
    } fetch_packet_t;
endpackage

// File: rtl/fetch_buffer.sv
// Queue of ICache fetch packets between ICache and decode, emitting one
// 32-bit instruction per cycle from the head packet.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [VADDR_BITS-1:0]   enq_pc,
    input  logic [FETCH_BYTES*8-1:0] enq_data,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [31:0]             deq_inst,
    output logic [VADDR_BITS-1:0]   deq_pc,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [1:0]        LAST_WORD = 2'(INSTS_PER_FETCH - 1);

    fetch_packet_t    mem [DEPTH];
    fetch_packet_t    head_pkt;
    logic [PTR_W-1:0] head, tail;
    logic [1:0]       idx, cur_idx;
    logic             fresh;
    logic             enq_fire, deq_fire, pop;
    logic             unused_pc_lsb;

    assign unused_pc_lsb = ^enq_pc[1:0];

    // A freshly promoted head starts at its own start index; later words come from idx.
    assign head_pkt = mem[head];
    assign cur_idx  = fresh ? head_pkt.start : idx;

    assign enq_ready = (count < FULL) && !flush;
    assign deq_valid = (count != '0) && !flush;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;
    assign pop       = deq_fire && (cur_idx == LAST_WORD);

    assign deq_inst = deq_valid ? head_pkt.data[32*cur_idx +: 32] : '0;
    assign deq_pc   = deq_valid ? {head_pkt.base, cur_idx, 2'b00} : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            idx   <= '0;
            fresh <= 1'b1;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            idx   <= '0;
            fresh <= 1'b1;
        end else begin
            if (enq_fire)
                tail <= tail + 1'b1;
            if (pop) begin
                head  <= head + 1'b1;
                idx   <= '0;
                fresh <= 1'b1;
            end else if (deq_fire) begin
                idx   <= cur_idx + 2'd1;
                fresh <= 1'b0;
            end
            case ({enq_fire, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (enq_fire)
            mem[tail] <= '{data: enq_data, base: enq_pc[VADDR_BITS-1:4], start: enq_pc[3:2]};
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: enqueue pushes expected words, a negedge monitor pops them.
module tb_fetch_buffer;
    logic         clock, reset;
    logic         enq_valid, enq_ready;
    logic [38:0]  enq_pc;
    logic [127:0] enq_data;
    logic         deq_valid, deq_ready;
    logic [31:0]  deq_inst;
    logic [38:0]  deq_pc;
    logic         flush;
    logic [2:0]   count;

    int passed = 0;
    int total  = 0;
    int mon_words = 0;
    logic [70:0] sb[$];

    fetch_buffer #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst), .deq_pc(deq_pc),
        .flush(flush), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one packet; expected words are queued right before the accepting edge.
    task automatic enq(input logic [38:0] pc, input logic [127:0] data);
        logic [1:0] w;
        bit done;
        done = 0;
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_data  = data;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clock);
            if (enq_ready) begin
                for (int i = 0; i < 4; i++) begin
                    w = 2'(i);
                    if (w >= pc[3:2])
                        sb.push_back({data[32*i +: 32], pc[38:4], w, 2'b00});
                end
                done = 1;
            end
            step();
        end
        if (!done) begin
            total++;
            $display("FAIL enq_timeout: pc %h never accepted", pc);
        end
        enq_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (sb.size() != 0 || count != 0); n++) step();
        check("drain_count", 128'(count), 128'd0);
        check("drain_sb_empty", 128'(sb.size()), 128'd0);
    endtask

    function automatic logic [127:0] pkt(input logic [15:0] tag);
        return {tag, 16'd3, tag, 16'd2, tag, 16'd1, tag, 16'd0};
    endfunction

    always @(negedge clock) begin
        if (!reset && deq_valid && deq_ready) begin
            mon_words++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL deq_unexpected: got inst %h pc %h, scoreboard empty", deq_inst, deq_pc);
            end else begin
                check("deq_word", 128'({deq_inst, deq_pc}), 128'(sb.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_pc = '0; enq_data = '0;
        #1;
        check("rst_enq_ready", 128'(enq_ready), 128'd1);
        check("rst_deq_valid", 128'(deq_valid), 128'd0);
        check("rst_deq_inst", 128'(deq_inst), 128'd0);
        check("rst_deq_pc", 128'(deq_pc), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        // Full packet, four consecutive words.
        deq_ready = 1'b1;
        sb.push_back({32'h11111111, 39'h1000});
        sb.push_back({32'h22222222, 39'h1004});
        sb.push_back({32'h33333333, 39'h1008});
        sb.push_back({32'h44444444, 39'h100C});
        enq_valid = 1'b1; enq_pc = 39'h1000;
        enq_data  = 128'h44444444_33333333_22222222_11111111;
        @(negedge clock);
        check("s1_no_bypass", 128'(deq_valid), 128'd0);
        step();
        enq_valid = 1'b0;
        for (int n = 0; n < 4; n++) step();
        check("s1_count_after", 128'(count), 128'd0);
        check("s1_sb_empty", 128'(sb.size()), 128'd0);

        // Start index 2: only two words.
        sb.push_back({32'hCCCC0002, 39'h2008});
        sb.push_back({32'hCCCC0003, 39'h200C});
        enq_valid = 1'b1; enq_pc = 39'h2008;
        enq_data  = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
        step();
        enq_valid = 1'b0;
        drain();

        // Fill to full with decode stalled.
        deq_ready = 1'b0;
        for (int k = 0; k < 4; k++) enq(39'h3000 + 39'(16*k), pkt(16'h3000 + 16'(k)));
        check("s3_count_full", 128'(count), 128'd4);
        check("s3_enq_ready", 128'(enq_ready), 128'd0);
        check("s3_head_inst", 128'(deq_inst), 128'h3000_0000);
        check("s3_head_pc", 128'(deq_pc), 128'h3000);
        step(); step();
        check("s3_hold_inst", 128'(deq_inst), 128'h3000_0000);
        check("s3_hold_pc", 128'(deq_pc), 128'h3000);
        enq_valid = 1'b1; enq_pc = 39'h3040; enq_data = pkt(16'h3004);
        step(); step(); step();
        check("s3_fifth_held", 128'(count), 128'd4);
        fork
            enq(39'h3040, pkt(16'h3004));
            begin step(); deq_ready = 1'b1; end
        join
        drain();

        // Streaming with random backpressure through pointer wrap.
        mon_words = 0;
        begin
            bit sdone;
            sdone = 0;
            fork
                begin
                    for (int k = 0; k < 10; k++) enq(39'h4000 + 39'(16*k), pkt(16'hA000 + 16'(k)));
                    sdone = 1;
                end
                begin
                    for (int n = 0; n < 3000 && !sdone; n++) begin
                        deq_ready = 1'($urandom_range(0, 1));
                        step();
                    end
                end
            join
        end
        deq_ready = 1'b1;
        drain();
        check("s4_word_total", 128'(mon_words), 128'd40);

        // Flush with count=3, word index=2, and a simultaneous enqueue.
        deq_ready = 1'b0;
        for (int k = 0; k < 3; k++) enq(39'h5000 + 39'(16*k), pkt(16'h5000 + 16'(k)));
        deq_ready = 1'b1;
        step(); step();
        deq_ready = 1'b0;
        check("s5_count3", 128'(count), 128'd3);
        check("s5_idx2_pc", 128'(deq_pc), 128'h5008);
        sb.delete();
        flush = 1'b1; enq_valid = 1'b1; enq_pc = 39'h6000; enq_data = pkt(16'h6000);
        @(negedge clock);
        check("s5_flush_enq_ready", 128'(enq_ready), 128'd0);
        check("s5_flush_deq_valid", 128'(deq_valid), 128'd0);
        step();
        flush = 1'b0; enq_valid = 1'b0;
        check("s5_count_cleared", 128'(count), 128'd0);
        check("s5_deq_valid", 128'(deq_valid), 128'd0);
        step(); step();
        check("s5_enq_discarded", 128'(count), 128'd0);
        deq_ready = 1'b1;
        enq(39'h7004, pkt(16'h7000));
        drain();

        // Asynchronous reset mid-stream.
        deq_ready = 1'b0;
        enq(39'h8000, pkt(16'h8000));
        enq(39'h8010, pkt(16'h8001));
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("s6_deq_valid", 128'(deq_valid), 128'd0);
        check("s6_enq_ready", 128'(enq_ready), 128'd1);
        check("s6_count", 128'(count), 128'd0);
        check("s6_deq_pc", 128'(deq_pc), 128'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        step(); step();
        check("s6_after_count", 128'(count), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
